// File: rtl/plaintext_byte_streamer_if.sv
// Bundle between the AES output side, the byte consumer and the plaintext streamer.
// Handshake: a byte moves on every rising edge where byte_valid_o and byte_ready_i are both high;
// once byte_valid_o rises, byte_o/last_o hold until that transfer, and ready may lead valid.
interface plaintext_byte_streamer_if #(
  parameter int TEXT_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
);
  logic                  finish_i;
  logic [TEXT_WIDTH-1:0] plaintext_i;
  logic                  full_o;
  logic                  overflow_o;
  logic [7:0]            byte_o;
  logic                  byte_valid_o;
  logic                  byte_ready_i;
  logic                  last_o;
  logic [CNT_WIDTH-1:0]  block_count_o;
  logic                  stream_state_o;

  modport slave (
    input  finish_i, plaintext_i, byte_ready_i,
    output full_o, overflow_o, byte_o, byte_valid_o, last_o, block_count_o, stream_state_o
  );

  modport master (
    output finish_i, plaintext_i, byte_ready_i,
    input  full_o, overflow_o, byte_o, byte_valid_o, last_o, block_count_o, stream_state_o
  );
endinterface

// File: rtl/plaintext_byte_streamer.sv
// Buffers AES plaintext blocks in a small FIFO and serializes them MSB-byte-first
// onto a valid/ready byte stream, counting fully streamed blocks.
module plaintext_byte_streamer #(
  parameter int TEXT_WIDTH = 128,
  parameter int DEPTH      = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  plaintext_byte_streamer_if.slave bus
);
  localparam int NB    = TEXT_WIDTH / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  state_t                r_state;
  logic [TEXT_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_overflow;
  logic [TEXT_WIDTH-1:0] r_shift;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_valid;
  logic                  r_last;
  logic [CNT_WIDTH-1:0]  r_block_count;

  logic                  w_xfer;
  logic                  w_final;
  logic                  w_nonempty;
  logic                  w_pop;
  logic                  w_push;
  logic [CW-1:0]         w_count_next;
  logic [TEXT_WIDTH-1:0] w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_xfer       = r_valid & bus.byte_ready_i;
  assign w_final      = w_xfer & r_last;
  assign w_nonempty   = (r_count != '0);
  // The shift register refills either from idle or on the final byte, so blocks run gap-free.
  assign w_pop        = w_nonempty & ((r_state == S_IDLE) | w_final);
  assign w_push       = bus.finish_i & ((r_count < CW'(DEPTH)) | w_pop);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  assign w_head       = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.plaintext_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
      if (bus.finish_i && !w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_idx         <= '0;
      r_valid       <= 1'b0;
      r_last        <= 1'b0;
      r_block_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift <= w_head;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_last  <= (NB == 1);
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (!r_last) begin
              r_shift <= r_shift << 8;
              r_idx   <= r_idx + IDX_W'(1);
              r_last  <= (r_idx == IDX_W'(NB - 2));
            end else begin
              r_block_count <= r_block_count + CNT_WIDTH'(1);
              if (w_pop) begin
                r_shift <= w_head;
                r_idx   <= '0;
                r_last  <= (NB == 1);
              end else begin
                r_shift <= '0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.byte_o         = r_shift[TEXT_WIDTH-1 -: 8];
  assign bus.byte_valid_o   = r_valid;
  assign bus.last_o         = r_last;
  assign bus.full_o         = r_full;
  assign bus.overflow_o     = r_overflow;
  assign bus.block_count_o  = r_block_count;
  assign bus.stream_state_o = r_state;
endmodule

// File: tb/tb_plaintext_byte_streamer.sv
// Bench for plaintext_byte_streamer: fixed vector table, directed corner sequences and
// random traffic checked against a queue-based reference model.
module tb_plaintext_byte_streamer;
  localparam int TW    = 128;
  localparam int DEPTH = 2;
  localparam int CW    = 16;

  typedef struct {
    bit             fin;
    logic [TW-1:0]  pt;
    bit             rdy;
    bit             e_valid;
    logic [7:0]     e_byte;
    bit             e_last;
  } vec_t;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  plaintext_byte_streamer_if #(.TEXT_WIDTH(TW), .CNT_WIDTH(CW)) bus ();
  plaintext_byte_streamer_if #(.TEXT_WIDTH(TW), .CNT_WIDTH(2))  bus2 ();

  assign bus2.finish_i     = bus.finish_i;
  assign bus2.plaintext_i  = bus.plaintext_i;
  assign bus2.byte_ready_i = bus.byte_ready_i;

  plaintext_byte_streamer #(.TEXT_WIDTH(TW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .bus(bus)
  );
  plaintext_byte_streamer #(.TEXT_WIDTH(TW), .DEPTH(DEPTH), .CNT_WIDTH(2)) dut_wrap (
    .clk_i(clk), .rst_i(rst_i), .bus(bus2)
  );

  // Reference model: pending blocks plus the bytes still owed from the block on the wire.
  logic [TW-1:0] m_fifo[$];
  logic [7:0]    exp_q[$];
  int            m_cnt;
  bit            m_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  bit         xfer_seen;
  bit         pre_valid;
  logic [7:0] pre_byte;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_cnt = 0;
    m_ovf = 0;
  endtask

  task automatic model_edge(input bit f, input logic [TW-1:0] p, input bit r);
    bit xfer, fin_x, pop, push_ok;
    int fl;
    logic [TW-1:0] blk;
    xfer    = (exp_q.size() > 0) && r;
    fin_x   = xfer && (exp_q.size() == 1);
    fl      = m_fifo.size();
    pop     = (fl > 0) && ((exp_q.size() == 0) || fin_x);
    push_ok = f && ((fl < DEPTH) || pop);
    if (xfer) void'(exp_q.pop_front());
    if (fin_x) m_cnt++;
    if (pop) begin
      blk = m_fifo.pop_front();
      for (int i = 0; i < TW / 8; i++) exp_q.push_back(blk[TW-1-8*i -: 8]);
    end
    if (f) begin
      if (push_ok) m_fifo.push_back(p);
      else m_ovf = 1;
    end
  endtask

  task automatic check_model();
    chk("valid", bus.byte_valid_o, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("byte", bus.byte_o, exp_q[0]);
      chk("last", bus.last_o, exp_q.size() == 1);
    end
    chk("full", bus.full_o, m_fifo.size() == DEPTH);
    chk("overflow", bus.overflow_o, m_ovf);
    chk("count", bus.block_count_o, m_cnt & 'hFFFF);
    chk("count_wrap", bus2.block_count_o, m_cnt % 4);
  endtask

  // Called just after a rising edge; drives inputs, advances one edge, checks the model.
  task automatic tick(input bit f, input logic [TW-1:0] p, input bit r);
    bus.finish_i     = f;
    bus.plaintext_i  = p;
    bus.byte_ready_i = r;
    pre_valid = bus.byte_valid_o;
    pre_byte  = bus.byte_o;
    xfer_seen = bus.byte_valid_o && r;
    @(posedge clk);
    model_edge(f, p, r);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    bus.finish_i     = 0;
    bus.plaintext_i  = '0;
    bus.byte_ready_i = 0;
    rst_i = 1;
    @(posedge clk);
    #1;
    rst_i = 0;
    model_reset();
  endtask

  function automatic logic [TW-1:0] rand_blk();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    vec_t vecs[18];
    logic [TW-1:0] blk_p;
    logic [1:0] wrap_exp[5];
    logic [7:0] got_q[$];
    int first_v, last_v, tot_v, n_x;
    int last_pos[$];

    blk_p = 128'h00112233445566778899aabbccddeeff;
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
    vecs[0] = '{fin: 1, pt: blk_p, rdy: 1, e_valid: 0, e_byte: 8'h00, e_last: 0};
    for (int k = 1; k <= 16; k++)
      vecs[k] = '{fin: 0, pt: '0, rdy: 1, e_valid: 1, e_byte: 8'((k - 1) * 8'h11), e_last: (k == 16)};
    vecs[17] = '{fin: 0, pt: '0, rdy: 1, e_valid: 0, e_byte: 8'h00, e_last: 0};

    // Reset state
    rst_i = 1;
    bus.finish_i = 0; bus.plaintext_i = '0; bus.byte_ready_i = 0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_byte", bus.byte_o, 0);
    chk("rst_valid", bus.byte_valid_o, 0);
    chk("rst_last", bus.last_o, 0);
    chk("rst_full", bus.full_o, 0);
    chk("rst_ovf", bus.overflow_o, 0);
    chk("rst_count", bus.block_count_o, 0);
    rst_i = 0;

    // Single block from the vector table
    for (int i = 0; i < 18; i++) begin
      tick(vecs[i].fin, vecs[i].pt, vecs[i].rdy);
      chk("vec_valid", bus.byte_valid_o, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        chk("vec_byte", bus.byte_o, vecs[i].e_byte);
        chk("vec_last", bus.last_o, vecs[i].e_last);
      end
    end
    chk("vec_count", bus.block_count_o, 1);

    // Backpressure
    do_reset();
    tick(1, blk_p, 0);
    for (int c = 0; c < 400 && got_q.size() < 16; c++) begin
      tick(0, '0, 1'($urandom_range(0, 1)));
      if (xfer_seen) got_q.push_back(pre_byte);
      else if (pre_valid) chk("stall_hold", bus.byte_o, pre_byte);
    end
    for (int c = 0; c < 4; c++) begin
      tick(0, '0, 1'($urandom_range(0, 1)));
      if (xfer_seen) got_q.push_back(pre_byte);
    end
    chk("bp_xfers", got_q.size(), 16);
    for (int i = 0; i < got_q.size() && i < 16; i++) chk("bp_byte", got_q[i], 8'(i * 8'h11));

    // Back-to-back blocks
    do_reset();
    first_v = -1; last_v = -1; tot_v = 0;
    for (int c = 0; c < 60; c++) begin
      tick((c == 0) || (c == 2), rand_blk(), 1);
      if (bus.byte_valid_o) begin
        if (first_v < 0) first_v = c;
        last_v = c;
        tot_v++;
        if (bus.last_o) last_pos.push_back(c - first_v + 1);
      end
    end
    chk("b2b_total", tot_v, 32);
    chk("b2b_span", last_v - first_v + 1, 32);
    chk("b2b_nlast", last_pos.size(), 2);
    if (last_pos.size() == 2) begin
      chk("b2b_last1", last_pos[0], 16);
      chk("b2b_last2", last_pos[1], 32);
    end
    chk("b2b_count", bus.block_count_o, 2);

    // Overflow
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, rand_blk(), 0);
    chk("ovf_full", bus.full_o, 1);
    chk("ovf_flag", bus.overflow_o, 1);
    n_x = 0;
    for (int c = 0; c < 200; c++) begin
      tick(0, '0, 1);
      if (xfer_seen) n_x++;
    end
    chk("ovf_bytes", n_x, 48);
    chk("ovf_sticky", bus.overflow_o, 1);

    // Reset mid-stream
    do_reset();
    tick(1, blk_p, 1);
    tick(1, rand_blk(), 1);
    for (int i = 0; i < 5; i++) tick(0, '0, 1);
    chk("pre_rst_byte", bus.byte_o, 8'h55);
    #2;
    rst_i = 1;
    #1;
    chk("mid_rst_byte", bus.byte_o, 0);
    chk("mid_rst_valid", bus.byte_valid_o, 0);
    chk("mid_rst_last", bus.last_o, 0);
    chk("mid_rst_full", bus.full_o, 0);
    chk("mid_rst_count", bus.block_count_o, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_i = 0;
    for (int i = 0; i < 6; i++) tick(0, '0, 1);
    chk("post_rst_quiet", bus.byte_valid_o, 0);
    tick(1, blk_p, 1);
    for (int i = 0; i < 20; i++) tick(0, '0, 1);
    chk("post_rst_count", bus.block_count_o, 1);

    // Counter wrap on the 2-bit instance
    do_reset();
    for (int b = 0; b < 5; b++) begin
      tick(1, rand_blk(), 1);
      for (int c = 0; c < 40; c++) begin
        tick(0, '0, 1);
        if (exp_q.size() == 0 && m_fifo.size() == 0) break;
      end
      chk("wrap_seq", bus2.block_count_o, wrap_exp[b]);
    end

    // Random traffic
    do_reset();
    for (int c = 0; c < 2500; c++)
      tick($urandom_range(0, 5) == 0, rand_blk(), $urandom_range(0, 2) != 0);
    for (int c = 0; c < 80; c++) tick(0, '0, 1);
    chk("rand_drained", bus.byte_valid_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
